// File: rtl/count_pulse_tx.sv
// Pulse transmitter: turns one-cycle REQ strobes into debounce-safe pulses of 2^DELAY high / 2^DELAY low.
// Define COUNT_PULSE_TX_INVERT_EN for an active-low PIN (idle high, pulses low).
module count_pulse_tx #(
  parameter int unsigned DELAY  = 16,
  parameter int unsigned PEND_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  output logic              PIN,
  output logic              BUSY,
  output logic              DONE,
  output logic [PEND_W-1:0] PENDING,
  output logic              OVF
);

`ifdef COUNT_PULSE_TX_INVERT_EN
  localparam logic PIN_ACT = 1'b0;
`else
  localparam logic PIN_ACT = 1'b1;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DELAY-1:0]    tmr_q, tmr_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                pin_q, pin_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                start;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          state_d = S_HIGH;
          tmr_d   = '0;
          start   = 1'b1;
        end
      end
      S_HIGH: begin
        if (tmr_q == '1) begin
          state_d = S_GAP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + DELAY'(1);
        end
      end
      S_GAP: begin
        if (tmr_q == '1) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + DELAY'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Outputs are flopped from next-state so they line up with state_q; DONE marks the final GAP clock.
  always_comb begin
    pin_d  = (state_d == S_HIGH) ? PIN_ACT : ~PIN_ACT;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_GAP) && (tmr_d == '1);
  end

  // Pending queue: a request and a pulse start in the same cycle cancel out.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    case ({REQ, start})
      2'b10: begin
        if (pend_q == '1) ovf_d = 1'b1;
        else              pend_d = pend_q + PEND_W'(1);
      end
      2'b01:   pend_d = pend_q - PEND_W'(1);
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      pin_q   <= ~PIN_ACT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      pin_q   <= pin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign PIN     = pin_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PENDING = pend_q;
  assign OVF     = ovf_q;

endmodule
